lsu_bus_initiator: RTL and testbench

//   Initiator side of the core's peripheral/data bus. Takes one load/store request at a time

---
 rtl/lsu_bus_initiator_pkg.sv | 32 +++
 rtl/lsu_bus_initiator_align.sv | 60 ++++++
 rtl/lsu_bus_initiator.sv | 167 ++++++++++++++++
 tb/tb_lsu_bus_initiator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_initiator_pkg.sv
// Shared LSU definitions: access size codes, initiator FSM states, READ_LATENCY limits
// and the alignment test shared by the initiator and the future cache path.
package lsu_bus_initiator_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam int unsigned READ_LATENCY_MIN = 32'd1;
   localparam int unsigned READ_LATENCY_MAX = 32'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_CAP     = 3'd3,
      ST_WR      = 3'd4,
      ST_RESP    = 3'd5,
      ST_ERR     = 3'd6
   } lsu_state_e;

   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SIZE_B:  mis = 1'b0;
         SIZE_H:  mis = lo[0];
         default: mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_bus_initiator_align.sv
// Little-endian lane logic: load extract with sign/zero extension, and the
// read-modify-write merge of a byte or halfword into an old word.
module lsu_bus_initiator_align
   import lsu_bus_initiator_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select and extension for loads; lane replacement for sub-word stores.
   always_comb begin
      byte_s     = 8'd0;
      half_s     = 16'd0;
      load_data  = rdata;
      store_word = rdata;
      case (addr_lo)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         default: byte_s = rdata[31:24];
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
      case (size)
         SIZE_B: begin
            load_data = is_unsigned ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            case (addr_lo)
               2'd0:    store_word[7:0]   = wdata[7:0];
               2'd1:    store_word[15:8]  = wdata[7:0];
               2'd2:    store_word[23:16] = wdata[7:0];
               default: store_word[31:24] = wdata[7:0];
            endcase
         end
         SIZE_H: begin
            load_data = is_unsigned ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            if (addr_lo[1]) begin
               store_word[31:16] = wdata[15:0];
            end else begin
               store_word[15:0] = wdata[15:0];
            end
         end
         default: begin
            load_data  = rdata;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_initiator.sv
// Load/store bus initiator: one request in flight, sub-word stores as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with rsp_err instead of aligning them.
module lsu_bus_initiator
   import lsu_bus_initiator_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 32'd1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic        bus_we,
   output logic        bus_re,
   input  logic [31:0] bus_read_data
);

   if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_latency_range
      $error("lsu_bus_initiator: READ_LATENCY must be in 1..3");
   end

   localparam logic [1:0] WAIT_LAST = (READ_LATENCY > 32'd1) ? 2'(READ_LATENCY - 32'd2) : 2'd0;

   lsu_state_e  state_r, state_next_s;
   logic [1:0]  cnt_r, cnt_next_s;
   logic        we_r, uns_r;
   logic [1:0]  size_r;
   logic [31:0] addr_r, wdata_r;
   logic        accept_s, misalign_s;
   logic [31:0] load_data_s, store_word_s;
   logic        req_ready_r, rsp_valid_r, rsp_err_r, bus_we_r, bus_re_r;
   logic [31:0] rsp_rdata_r, bus_address_r, bus_write_data_r;

   assign accept_s = (state_r == ST_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_s = lsu_misaligned(req_size, req_addr[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   lsu_bus_initiator_align u_align (
      .size        (size_r),
      .is_unsigned (uns_r),
      .addr_lo     (addr_r[1:0]),
      .rdata       (bus_read_data),
      .wdata       (wdata_r),
      .load_data   (load_data_s),
      .store_word  (store_word_s)
   );

   // FSM state and read-latency counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 2'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (!req_valid) begin
               state_next_s = ST_IDLE;
            end else if (misalign_s) begin
               state_next_s = ST_ERR;
            end else if (req_we && (req_size == SIZE_W || req_size == 2'b11)) begin
               state_next_s = ST_WR;
            end else begin
               state_next_s = ST_RD;
            end
         end
         ST_RD: begin
            cnt_next_s = 2'd0;
            if (READ_LATENCY > 32'd1) begin
               state_next_s = ST_RD_WAIT;
            end else begin
               state_next_s = ST_CAP;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_r == WAIT_LAST) begin
               state_next_s = ST_CAP;
            end else begin
               cnt_next_s = cnt_r + 2'd1;
            end
         end
         ST_CAP: begin
            if (we_r) begin
               state_next_s = ST_WR;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         ST_WR:   state_next_s = ST_RESP;
         ST_RESP: state_next_s = ST_IDLE;
         ST_ERR:  state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Request latch plus registered bus/response outputs, decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_r             <= 1'b0;
         uns_r            <= 1'b0;
         size_r           <= 2'b00;
         addr_r           <= 32'd0;
         wdata_r          <= 32'd0;
         req_ready_r      <= 1'b1;
         rsp_valid_r      <= 1'b0;
         rsp_err_r        <= 1'b0;
         rsp_rdata_r      <= 32'd0;
         bus_re_r         <= 1'b0;
         bus_we_r         <= 1'b0;
         bus_address_r    <= 32'd0;
         bus_write_data_r <= 32'd0;
      end else begin
         req_ready_r <= (state_next_s == ST_IDLE);
         bus_re_r    <= (state_next_s == ST_RD);
         bus_we_r    <= (state_next_s == ST_WR);
         rsp_valid_r <= (state_next_s == ST_RESP) || (state_next_s == ST_ERR);
         rsp_err_r   <= (state_next_s == ST_ERR);
         rsp_rdata_r <= (state_r == ST_CAP && state_next_s == ST_RESP) ? load_data_s : 32'd0;
         if (accept_s) begin
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            size_r  <= req_size;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
         end
         // Address and data hold between strobes; a trapped request leaves them untouched.
         if (accept_s && state_next_s != ST_ERR) begin
            bus_address_r <= {req_addr[31:2], 2'b00};
         end
         if (state_next_s == ST_WR) begin
            bus_write_data_r <= (state_r == ST_CAP) ? store_word_s : req_wdata;
         end
      end
   end

   assign req_ready      = req_ready_r;
   assign rsp_valid      = rsp_valid_r;
   assign rsp_err        = rsp_err_r;
   assign rsp_rdata      = rsp_rdata_r;
   assign bus_re         = bus_re_r;
   assign bus_we         = bus_we_r;
   assign bus_address    = bus_address_r;
   assign bus_write_data = bus_write_data_r;

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Bench for lsu_bus_initiator: two instances (READ_LATENCY 1 and 3), a word-memory responder,
// directed cases then random requests checked against an arithmetic reference model.
module tb_lsu_bus_initiator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset        [2];
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic        req_we       [2];
   logic [1:0]  req_size     [2];
   logic        req_unsigned [2];
   logic [31:0] req_addr     [2];
   logic [31:0] req_wdata    [2];
   logic        rsp_valid    [2];
   logic [31:0] rsp_rdata    [2];
   logic        rsp_err      [2];
   logic [31:0] bus_address  [2];
   logic [31:0] bus_write_data [2];
   logic        bus_we       [2];
   logic        bus_re       [2];
   logic [31:0] bus_read_data [2];

   logic [31:0] mem [2][256];
   logic [7:0]  pend [2] = '{8'd0, 8'd0};
   int          rcnt [2] = '{0, 0};

   int n_run  = 0;
   int n_fail = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lsu_bus_initiator #(.READ_LATENCY((g == 0) ? 1 : 3)) u_dut (
         .clk            (clk),
         .reset          (reset[g]),
         .req_valid      (req_valid[g]),
         .req_ready      (req_ready[g]),
         .req_we         (req_we[g]),
         .req_size       (req_size[g]),
         .req_unsigned   (req_unsigned[g]),
         .req_addr       (req_addr[g]),
         .req_wdata      (req_wdata[g]),
         .rsp_valid      (rsp_valid[g]),
         .rsp_rdata      (rsp_rdata[g]),
         .rsp_err        (rsp_err[g]),
         .bus_address    (bus_address[g]),
         .bus_write_data (bus_write_data[g]),
         .bus_we         (bus_we[g]),
         .bus_re         (bus_re[g]),
         .bus_read_data  (bus_read_data[g])
      );
   end

   function automatic int rl(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Responder: read data is valid only in cycle T+READ_LATENCY, inverted garbage otherwise.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (bus_re[d]) begin
            pend[d] <= bus_address[d][9:2];
            rcnt[d] <= rl(d);
         end else if (rcnt[d] > 0) begin
            rcnt[d] <= rcnt[d] - 1;
         end
      end
   end

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         bus_read_data[d] = (rcnt[d] == 1) ? mem[d][pend[d]] : ~mem[d][pend[d]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
      logic [31:0] old_w, exp_rd, exp_w, got_rd, got_wd, re_addr, we_addr, exp_addr;
      logic [1:0]  sz;
      logic [7:0]  b8;
      logic [15:0] h16;
      logic        mis, got_err;
      int bsh, hsh, exp_lat, exp_re, exp_we, exp_we_at, lat, nre, nwe, re_at, we_at;
      string t;
      t        = $sformatf("%s.d%0d", tag, d);
      old_w    = mem[d][addr[9:2]];
      sz       = (size == 2'b11) ? 2'd2 : size;
      bsh      = 8 * int'(addr[1:0]);
      hsh      = 16 * int'(addr[1]);
      exp_addr = addr & 32'hFFFF_FFFC;
      mis      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
`endif
      exp_rd = 32'd0;
      exp_w  = old_w;
      if (!we) begin
         if (sz == 2'd0) begin
            b8 = 8'((old_w >> bsh) & 32'hFF);
            exp_rd = uns ? {24'd0, b8} : {{24{b8[7]}}, b8};
         end else if (sz == 2'd1) begin
            h16 = 16'((old_w >> hsh) & 32'hFFFF);
            exp_rd = uns ? {16'd0, h16} : {{16{h16[15]}}, h16};
         end else begin
            exp_rd = old_w;
         end
      end else if (sz == 2'd0) begin
         exp_w = (old_w & ~(32'hFF << bsh)) | ((wdata & 32'hFF) << bsh);
      end else if (sz == 2'd1) begin
         exp_w = (old_w & ~(32'hFFFF << hsh)) | ((wdata & 32'hFFFF) << hsh);
      end else begin
         exp_w = wdata;
      end
      exp_we_at = 0;
      if (mis) begin
         exp_lat = 1; exp_re = 0; exp_we = 0; exp_rd = 32'd0;
      end else if (we && sz == 2'd2) begin
         exp_lat = 2; exp_re = 0; exp_we = 1; exp_we_at = 1;
      end else if (we) begin
         exp_lat = 3 + rl(d); exp_re = 1; exp_we = 1; exp_we_at = 2 + rl(d);
      end else begin
         exp_lat = 2 + rl(d); exp_re = 1; exp_we = 0;
      end

      @(negedge clk);
      chk({t, ".ready"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
      req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wdata;
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      lat = 0; nre = 0; nwe = 0; re_at = 0; we_at = 0;
      got_rd = 32'd0; got_wd = 32'd0; got_err = 1'b0; re_addr = 32'd0; we_addr = 32'd0;
      for (int k = 1; k <= 24 && lat == 0; k++) begin
         @(negedge clk);
         if (bus_re[d]) begin
            nre++; re_at = k; re_addr = bus_address[d];
         end
         if (bus_we[d]) begin
            nwe++; we_at = k; we_addr = bus_address[d]; got_wd = bus_write_data[d];
            mem[d][bus_address[d][9:2]] = bus_write_data[d];
         end
         if (rsp_valid[d]) begin
            lat = k; got_rd = rsp_rdata[d]; got_err = rsp_err[d];
         end
      end
      chk({t, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({t, ".re_count"}, 32'(nre), 32'(exp_re));
      chk({t, ".we_count"}, 32'(nwe), 32'(exp_we));
      chk({t, ".rdata"}, got_rd, exp_rd);
      chk({t, ".err"}, 32'(got_err), 32'(mis));
      if (exp_re > 0) begin
         chk({t, ".re_cycle"}, 32'(re_at), 32'd1);
         chk({t, ".re_addr"}, re_addr, exp_addr);
      end
      if (exp_we > 0) begin
         chk({t, ".we_cycle"}, 32'(we_at), 32'(exp_we_at));
         chk({t, ".we_addr"}, we_addr, exp_addr);
         chk({t, ".we_data"}, got_wd, exp_w);
      end
      @(negedge clk);
      chk({t, ".after_quiet"}, {29'd0, rsp_valid[d], bus_re[d], bus_we[d]}, 32'd0);
      chk({t, ".after_ready"}, 32'(req_ready[d]), 32'd1);
   endtask

   task automatic abort_op(input int d, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input int at_k, input logic we_before,
                           input string tag);
      string t;
      t = $sformatf("%s.d%0d", tag, d);
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
      req_unsigned[d] = 1'b0; req_addr[d] = addr; req_wdata[d] = 32'h5A5A_5A5A;
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      repeat (at_k) @(negedge clk);
      chk({t, ".we_before"}, 32'(bus_we[d]), 32'(we_before));
      #1 reset[d] = 1'b1;
      #1;
      chk({t, ".strobes_drop"}, {30'd0, bus_re[d], bus_we[d]}, 32'd0);
      chk({t, ".rsp_in_reset"}, 32'(rsp_valid[d]), 32'd0);
      @(negedge clk);
      reset[d] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("%s.quiet%0d", t, k), {29'd0, rsp_valid[d], bus_re[d], bus_we[d]}, 32'd0);
      end
      chk({t, ".ready_after"}, 32'(req_ready[d]), 32'd1);
   endtask

   task automatic directed(input int d);
      mem[d][8'h40] = 32'hDEAD_BEEF;
      do_op(d, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "lw");
      mem[d][8'h40] = 32'h80FF_0000;
      do_op(d, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, "lb");
      do_op(d, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, "lbu");
      do_op(d, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, "lh");
      do_op(d, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, "lhu");
      mem[d][8'h40] = 32'h1122_3344;
      do_op(d, 1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FFAB, "sb");
      chk($sformatf("sb_mem.d%0d", d), mem[d][8'h40], 32'h1122_AB44);
      do_op(d, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_BEEF, "sh");
      chk($sformatf("sh_mem.d%0d", d), mem[d][8'h40], 32'hBEEF_AB44);
      do_op(d, 1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFE_F00D, "sw");
      chk($sformatf("sw_mem.d%0d", d), mem[d][8'h80], 32'hCAFE_F00D);
      do_op(d, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, "lw_mis");
      do_op(d, 1'b0, 2'b11, 1'b0, 32'h104, 32'h0, "size3");
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
         req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
         for (int i = 0; i < 256; i++) mem[d][i] = $urandom;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_ready.d%0d", d), 32'(req_ready[d]), 32'd1);
         chk($sformatf("reset_ctl.d%0d", d),
             {28'd0, rsp_valid[d], rsp_err[d], bus_re[d], bus_we[d]}, 32'd0);
         chk($sformatf("reset_addr.d%0d", d), bus_address[d], 32'd0);
         chk($sformatf("reset_wdata.d%0d", d), bus_write_data[d], 32'd0);
         chk($sformatf("reset_rdata.d%0d", d), rsp_rdata[d], 32'd0);
         reset[d] = 1'b0;
      end
      directed(0);
      directed(1);
      abort_op(1, 1'b1, 2'b01, 32'h102, 2, 1'b0, "abort_sh");
      abort_op(0, 1'b1, 2'b10, 32'h300, 1, 1'b1, "abort_sw");
      abort_op(0, 1'b0, 2'b10, 32'h300, 1, 1'b0, "abort_lw");
      do_op(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "post_abort");
      for (int i = 0; i < 60; i++) begin
         do_op(i % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom, "rnd");
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
